robo_wall_follower: RTL

//  Parametrised wall-following controller; successor to the 4-state h/l robot FSM.

---
 rtl/robo_pkg.sv | 49 ++++
 rtl/robo_debounce.sv | 31 +++
 rtl/robo_wall_follower.sv | 74 +++++++
 3 files changed

// File: rtl/robo_pkg.sv
// Shared state encoding and the raw wall-follow transition table for robo_wall_follower.
// Committed-turn and stuck handling are layered on top of this table in the top module.
package robo_pkg;

  typedef enum logic [2:0] {
    INICIO = 3'd0,
    FRENTE = 3'd1,
    LADO   = 3'd2,
    FL     = 3'd3,
    HALT   = 3'd4
  } state_t;

  function automatic logic is_turn(input state_t s);
    return (s == FRENTE) || (s == FL);
  endfunction

  // Plain table on filtered {h,l}; HALT exit is handled separately via clr_stuck.
  function automatic state_t fsm_next(input state_t s, input logic hf, input logic lf);
    state_t n;
    n = INICIO;
    case (s)
      INICIO: case ({hf, lf})
                2'b00:   n = INICIO;
                2'b01:   n = LADO;
                2'b10:   n = FRENTE;
                default: n = FL;
              endcase
      FRENTE: case ({hf, lf})
                2'b01:   n = LADO;
                2'b11:   n = FL;
                default: n = FRENTE;
              endcase
      LADO:   case ({hf, lf})
                2'b01:   n = LADO;
                2'b11:   n = FL;
                default: n = INICIO;
              endcase
      FL:     case ({hf, lf})
                2'b10:   n = FRENTE;
                2'b01:   n = LADO;
                default: n = FL;
              endcase
      HALT:   n = HALT;
      default: n = INICIO;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/robo_debounce.sv
// Single-sensor debouncer: the filtered value flips only after the raw input has
// disagreed with it for DEBOUNCE_CYCLES consecutive edges.
module robo_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      // this edge is the DEBOUNCE_CYCLES-th disagreeing one
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/robo_wall_follower.sv
// Wall-following controller: debounced h/l sensors drive a Moore FSM with a
// minimum committed turn and a stuck-turning watchdog that parks the robot in HALT.
module robo_wall_follower
  import robo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_CYCLES     = 8,
  parameter int STUCK_LIMIT     = 32,
  parameter int CNT_W           = $clog2(STUCK_LIMIT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       h,
  input  logic       l,
  input  logic       clr_stuck,
  output logic       f,
  output logic       g,
  output logic       stuck,
  output logic [2:0] state_o
);

  logic             hf, lf;
  state_t           state, tbl_nxt, nxt;
  logic [CNT_W-1:0] turn_cnt, turn_inc;

  robo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_h (
    .clk(clk), .rst(rst), .raw(h), .filt(hf)
  );
  robo_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
    .clk(clk), .rst(rst), .raw(l), .filt(lf)
  );

  // A turn that has not yet lasted TURN_CYCLES refuses to hand over to a forward state.
  always_comb begin
    tbl_nxt = fsm_next(state, hf, lf);
    nxt     = tbl_nxt;
    if (is_turn(state) && !is_turn(tbl_nxt) && (turn_cnt < CNT_W'(TURN_CYCLES - 1)))
      nxt = state;
  end

  assign turn_inc = (turn_cnt == CNT_W'(STUCK_LIMIT)) ? turn_cnt : turn_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INICIO;
      turn_cnt <= '0;
    end else if (en) begin
      if (state == HALT) begin
        if (clr_stuck) begin
          state    <= INICIO;
          turn_cnt <= '0;
        end
      end else if (is_turn(state) && is_turn(nxt)) begin
        if (turn_cnt == CNT_W'(STUCK_LIMIT - 1)) begin
          state    <= HALT;
          turn_cnt <= '0;
        end else begin
          state    <= nxt;
          turn_cnt <= turn_inc;
        end
      end else begin
        state    <= nxt;
        turn_cnt <= '0;
      end
    end
  end

  assign f       = en && ((state == INICIO) || (state == LADO));
  assign g       = en && ((state == FRENTE) || (state == FL));
  assign stuck   = (state == HALT);
  assign state_o = state;

endmodule
